// File: rtl/ad73_pkg.sv
// Shared definitions for the AD73-class serial port responder: control-word
// field positions, register-file geometry and the port state enum.
package ad73_pkg;

  localparam int CR_COUNT = 8;
  localparam int WORD_W   = 16;

  localparam int MODE_BIT = 15;
  localparam int WR_BIT   = 14;
  localparam int ADDR_MSB = 10;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic {
    PROGRAM = 1'b0,
    DATA    = 1'b1
  } state_t;

endpackage

// File: rtl/ad73_sclk_gen.sv
// Serial clock generator: divides clk by 2*SCLK_DIV, freezes while se is low
// and flags the clk cycle in which SCLK rises or falls.
module ad73_sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_l,
  input  logic se,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          toggle;

  // Strobes coincide with the clk edge that flips SCLK, so the consumer
  // updates on exactly the same edge as the serial clock.
  assign toggle   = se && (div_cnt == DIV_LAST);
  assign rise_stb = toggle && !sclk;
  assign fall_stb = toggle && sclk;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (se) begin
      if (toggle) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad73_sport_responder.sv
// Codec-side model of an AD73-class serial port for controller loopback.
// Optional readback of CR[addr] on WR=0 words: macro ADC_RESP_READBACK_EN.
module ad73_sport_responder
  import ad73_pkg::*;
#(
  parameter int SCLK_DIV     = 2,
  parameter int FRAME_PERIOD = 32
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              SE,
  output logic              SCLK,
  output logic              SDOFS,
  output logic              SDO,
  input  logic              SDIFS,
  input  logic              SDI,
  input  logic [WORD_W-1:0] sample_i,
  output logic              sample_ack_o,
  output logic [WORD_W-1:0] rx_word_o,
  output logic              rx_valid_o,
  output logic [63:0]       reg_file_o,
  output logic              data_mode_o
);

  localparam int FCW = $clog2(FRAME_PERIOD);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_PERIOD - 1);

  logic              rise_stb;
  logic              fall_stb;
  logic              frame_start;
  state_t            state;
  logic              data_pending;
  logic [FCW-1:0]    frame_cnt;
  logic [WORD_W-1:0] tx_shift;
  logic [WORD_W-1:0] tx_next;
  logic [WORD_W-2:0] rx_shift;
  logic [WORD_W-1:0] rx_full;
  logic [3:0]        rx_cnt;
  logic [7:0]        cr [CR_COUNT];
`ifdef ADC_RESP_READBACK_EN
  logic              rb_pending;
  logic [WORD_W-1:0] rb_word;
`endif

  ad73_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst_l    (rst_l),
    .se       (SE),
    .sclk     (SCLK),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign frame_start = fall_stb && (frame_cnt == '0);
  assign rx_full     = {rx_shift, SDI};
  assign data_mode_o = (state == DATA);

  always_comb begin
    tx_next = rx_word_o;
`ifdef ADC_RESP_READBACK_EN
    if (rb_pending) tx_next = rb_word;
`endif
    if (state == DATA) tx_next = sample_i;
  end

  always_comb begin
    reg_file_o = '0;
    for (int i = 0; i < CR_COUNT; i++) reg_file_o[8*i +: 8] = cr[i];
  end

  // Receive shifter, control-word decode and state. A SDIFS pulse always
  // restarts the capture so the newest frame wins.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state        <= PROGRAM;
      data_pending <= 1'b0;
      rx_shift     <= '0;
      rx_cnt       <= '0;
      rx_word_o    <= '0;
      rx_valid_o   <= 1'b0;
      for (int i = 0; i < CR_COUNT; i++) cr[i] <= '0;
`ifdef ADC_RESP_READBACK_EN
      rb_pending   <= 1'b0;
      rb_word      <= '0;
`endif
    end else begin
      rx_valid_o <= 1'b0;
      if (rise_stb) begin
        if (SDIFS) begin
          rx_shift <= {{(WORD_W-2){1'b0}}, SDI};
          rx_cnt   <= 4'd1;
        end else if (rx_cnt != '0) begin
          rx_shift <= rx_full[WORD_W-2:0];
          if (rx_cnt == 4'd15) begin
            rx_cnt     <= '0;
            rx_word_o  <= rx_full;
            rx_valid_o <= 1'b1;
            if (state == PROGRAM && rx_full[WR_BIT]) begin
              cr[rx_full[ADDR_MSB:ADDR_LSB]] <= rx_full[DATA_MSB:DATA_LSB];
              if (rx_full[MODE_BIT]) data_pending <= 1'b1;
            end
`ifdef ADC_RESP_READBACK_EN
            if (state == PROGRAM && !rx_full[WR_BIT]) begin
              rb_pending <= 1'b1;
              rb_word    <= {rx_full[WORD_W-1:8], cr[rx_full[ADDR_MSB:ADDR_LSB]]};
            end
`endif
          end else begin
            rx_cnt <= rx_cnt + 4'd1;
          end
        end
      end
      // Mode change and readback are consumed at the frame boundary; the TX
      // word for that frame was already chosen from the old state.
      if (frame_start) begin
        if (data_pending) state <= DATA;
        data_pending <= 1'b0;
`ifdef ADC_RESP_READBACK_EN
        rb_pending   <= 1'b0;
`endif
      end
    end
  end

  // Frame counter and transmit shifter, advancing on SCLK falling edges only.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      frame_cnt    <= '0;
      tx_shift     <= '0;
      SDOFS        <= 1'b0;
      SDO          <= 1'b0;
      sample_ack_o <= 1'b0;
    end else begin
      sample_ack_o <= 1'b0;
      if (fall_stb) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
        SDOFS     <= frame_start;
        if (frame_start) begin
          SDO          <= tx_next[WORD_W-1];
          tx_shift     <= {tx_next[WORD_W-2:0], 1'b0};
          sample_ack_o <= (state == DATA);
        end else if (frame_cnt < FCW'(WORD_W)) begin
          SDO      <= tx_shift[WORD_W-1];
          tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
        end else begin
          SDO <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ad73_sport_responder.sv
// Directed bench for ad73_sport_responder (SCLK_DIV=2, FRAME_PERIOD=32);
// acts as the controller end and decodes SDO frames with a passive monitor.
module tb_ad73_sport_responder;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        SE;
  logic        SCLK;
  logic        SDOFS;
  logic        SDO;
  logic        SDIFS;
  logic        SDI;
  logic [15:0] sample_i;
  logic        sample_ack_o;
  logic [15:0] rx_word_o;
  logic        rx_valid_o;
  logic [63:0] reg_file_o;
  logic        data_mode_o;

  int checks   = 0;
  int failures = 0;

  // monitor state
  int          clk_count    = 0;
  int          rise_idx     = 0;
  int          last_rise    = 0;
  int          sclk_period  = 0;
  int          last_fs_rise = 0;
  int          fs_gap       = 0;
  int          fs_run       = 0;
  int          fs_len       = 0;
  int          fs_count     = 0;
  int          tx_bits      = 0;
  int          tx_frames    = 0;
  int          ack_count    = 0;
  int          rxv_count    = 0;
  int          outside_ones = 0;
  logic        prev_sclk    = 1'b0;
  logic [15:0] mon_shift    = '0;
  logic [15:0] last_tx      = '0;

  ad73_sport_responder #(
    .SCLK_DIV     (2),
    .FRAME_PERIOD (32)
  ) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .SE           (SE),
    .SCLK         (SCLK),
    .SDOFS        (SDOFS),
    .SDO          (SDO),
    .SDIFS        (SDIFS),
    .SDI          (SDI),
    .sample_i     (sample_i),
    .sample_ack_o (sample_ack_o),
    .rx_word_o    (rx_word_o),
    .rx_valid_o   (rx_valid_o),
    .reg_file_o   (reg_file_o),
    .data_mode_o  (data_mode_o)
  );

  always #5 clk = ~clk;

  // Passive decoder: SDO is read on SCLK rising edges, frame begins where SDOFS is high.
  always @(negedge clk) begin
    clk_count++;
    if (!rst_l) begin
      tx_bits   = 0;
      prev_sclk = 1'b0;
      fs_run    = 0;
    end else begin
      if (SDOFS) fs_run++;
      else if (fs_run != 0) begin
        fs_len = fs_run;
        fs_run = 0;
      end
      if (sample_ack_o) ack_count++;
      if (rx_valid_o) rxv_count++;
      if (!prev_sclk && SCLK) begin
        rise_idx++;
        sclk_period = clk_count - last_rise;
        last_rise   = clk_count;
        if (SDOFS) begin
          fs_gap       = rise_idx - last_fs_rise;
          last_fs_rise = rise_idx;
          fs_count++;
          mon_shift = {15'b0, SDO};
          tx_bits   = 1;
        end else if (tx_bits > 0 && tx_bits < 16) begin
          mon_shift = {mon_shift[14:0], SDO};
          tx_bits++;
          if (tx_bits == 16) begin
            last_tx = mon_shift;
            tx_frames++;
          end
        end else if (SDO) begin
          outside_ones++;
        end
      end
      prev_sclk = SCLK;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got timeout expected event", tag);
  endtask

  // Called at a negedge; returns at the negedge right after SCLK falls.
  task automatic waitFall();
    logic cur;
    bit   ok;
    cur = SCLK;
    ok  = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (cur && !SCLK) ok = 1;
      cur = SCLK;
    end
    if (!ok) timeoutFail("sclk_fall");
  endtask

  task automatic waitFrameStart();
    int  start;
    bit  ok;
    start = fs_count;
    ok    = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (fs_count != start) ok = 1;
    end
    if (!ok) timeoutFail("frame_start");
  endtask

  task automatic waitFrameDone();
    int  start;
    bit  ok;
    start = tx_frames;
    ok    = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (tx_frames != start) ok = 1;
    end
    if (!ok) timeoutFail("frame_done");
  endtask

  // Controller side: drive on SCLK falling edges, MSB first, SDIFS with bit 15.
  task automatic applyStimulus(input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      waitFall();
      SDIFS = (i == 15);
      SDI   = w[i];
    end
    waitFall();
    SDIFS = 1'b0;
    SDI   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] w;
    logic        hold_sclk, hold_sdo, hold_fs;
    bit          changed;
    int          rise_snap;
    logic [15:0] exp_rb;

    rst_l    = 1'b0;
    SE       = 1'b0;
    SDIFS    = 1'b0;
    SDI      = 1'b0;
    sample_i = 16'h0000;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    checkOutput("rst_sclk", SCLK, 0);
    checkOutput("rst_sdofs", SDOFS, 0);
    checkOutput("rst_sdo", SDO, 0);
    checkOutput("rst_regfile", reg_file_o, 64'h0);
    checkOutput("rst_rx_word", rx_word_o, 0);
    checkOutput("rst_data_mode", data_mode_o, 0);
    repeat (10) @(negedge clk);
    checkOutput("se_low_sclk_idle", SCLK, 0);

    $display("[TB] framing with empty echo");
    SE = 1'b1;
    waitFrameStart();
    checkOutput("sclk_period_clk", sclk_period, 4);
    waitFrameDone();
    checkOutput("empty_echo", last_tx, 16'h0000);
    waitFrameStart();
    checkOutput("sdofs_gap_sclk", fs_gap, 32);
    checkOutput("sdofs_len_clk", fs_len, 4);

    $display("[TB] single register write and echo");
    applyStimulus(16'h4105, 16);
    checkOutput("rx_valid_count_1", rxv_count, 1);
    checkOutput("rx_word_4105", rx_word_o, 16'h4105);
    checkOutput("cr1_write", reg_file_o, 64'h0000_0000_0000_0500);
    waitFrameDone();
    checkOutput("echo_4105", last_tx, 16'h4105);

    $display("[TB] fill register file then enter data mode");
    for (int a = 0; a < 8; a++) begin
      w = 16'h4000 | (16'(a) << 8) | 16'(a);
      applyStimulus(w, 16);
    end
    sample_i = 16'hA5C3;
    waitFrameStart();
    applyStimulus(16'hC008, 16);
    checkOutput("rx_valid_count_10", rxv_count, 10);
    checkOutput("regfile_all", reg_file_o, 64'h0706_0504_0302_0108);
    checkOutput("data_mode_pending", data_mode_o, 0);
    waitFrameDone();
    checkOutput("transition_frame_echo", last_tx, 16'hC008);
    checkOutput("data_mode_set", data_mode_o, 1);
    checkOutput("ack_before_data", ack_count, 0);
    waitFrameDone();
    checkOutput("sample_on_sdo", last_tx, 16'hA5C3);
    checkOutput("ack_first_sample", ack_count, 1);

    $display("[TB] write attempt in data mode");
    applyStimulus(16'h4255, 16);
    checkOutput("rx_valid_count_11", rxv_count, 11);
    checkOutput("rx_word_4255", rx_word_o, 16'h4255);
    checkOutput("data_mode_no_write", reg_file_o, 64'h0706_0504_0302_0108);

    $display("[TB] SE freeze mid-frame");
    sample_i = 16'h5A3C;
    waitFrameStart();
    waitFrameStart();
    repeat (5) waitFall();
    hold_sclk = SCLK;
    hold_sdo  = SDO;
    hold_fs   = SDOFS;
    rise_snap = rise_idx;
    SE        = 1'b0;
    changed   = 0;
    repeat (40) begin
      @(negedge clk);
      if (SCLK !== hold_sclk || SDO !== hold_sdo || SDOFS !== hold_fs) changed = 1;
    end
    checkOutput("se_freeze_hold", changed, 0);
    checkOutput("se_freeze_no_rise", rise_idx - rise_snap, 0);
    SE = 1'b1;
    waitFrameDone();
    checkOutput("frame_after_freeze", last_tx, 16'h5A3C);

    $display("[TB] reset mid-receive");
    applyStimulus(16'h4377, 8);
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_regfile", reg_file_o, 64'h0);
    checkOutput("midrst_data_mode", data_mode_o, 0);
    checkOutput("midrst_rx_word", rx_word_o, 0);
    checkOutput("midrst_sclk", SCLK, 0);
    rst_l = 1'b1;
    @(negedge clk);
    waitFrameStart();
    applyStimulus(16'h4307, 16);
    checkOutput("rx_valid_count_12", rxv_count, 12);
    checkOutput("cr3_after_reset", reg_file_o, 64'h0000_0000_0700_0000);
    waitFrameDone();
    checkOutput("echo_4307", last_tx, 16'h4307);

    $display("[TB] read command");
    waitFrameStart();
    applyStimulus(16'h0300, 16);
    checkOutput("rx_valid_count_13", rxv_count, 13);
    checkOutput("read_no_write", reg_file_o, 64'h0000_0000_0700_0000);
`ifdef ADC_RESP_READBACK_EN
    exp_rb = 16'h0307;
`else
    exp_rb = 16'h0300;
`endif
    waitFrameDone();
    checkOutput("readback_frame", last_tx, exp_rb);
    waitFrameDone();
    checkOutput("echo_after_read", last_tx, 16'h0300);
    checkOutput("sdo_zero_outside_window", outside_ones, 0);
    checkOutput("sdofs_len_final", fs_len, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
